pong_game_ctrl: RTL
===================

# pong_game_ctrl

Game-flow sequencer for the pong display pipeline. It owns match state (idle, serve, play, pause, point, game over), keeps both players' scores, and gates the ball/paddle animation datapath through a motion enable and a ball-recentre pulse. It sits between the player start button, the per-frame tick, and the miss indications from the animation datapath. Scores and winner feed the score overlay.

## Interface
Parameters:
- MAX_SCORE, 7: points needed to win; legal range 1..15.
- SERVE_FRAMES, 60: frame ticks spent in SERVE before play starts; legal range 1..255.
- POINT_FRAMES, 90: frame ticks spent in POINT after a score; legal range 1..255.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  reset, synchronous, active-high.
- frame_tick  in  1  one-cycle pulse, once per frame at the end of the last visible line.
- start  in  1  debounced start/pause button, level.
- miss_l  in  1  one-cycle pulse: ball passed the left paddle, point to P2.
- miss_r  in  1  one-cycle pulse: ball passed the right paddle, point to P1.
- motion_en  out  1  datapath may advance ball and paddles on frame_tick.
- ball_center  out  1  one-cycle pulse: datapath reloads the ball to screen centre.
- serve_dir  out  1  initial ball x-direction after recentre: 0 = toward left, 1 = toward right.
- score1  out  4  P1 (left) score.
- score2  out  4  P2 (right) score.
- winner  out  2  00 = none, 01 = P1, 10 = P2.
- state  out  3  current state encoding, for debug and overlay.

## Operation
- start_rise = start & ~start_q, where start_q is start registered one cycle.
- IDLE (000): motion_en = 0. On start_rise: clear scores and winner, set serve_dir = 0, go to SERVE.
- SERVE (001): motion_en = 0. Frame counter counts frame_tick. On the SERVE_FRAMES-th tick, go to PLAY.
- PLAY (010): motion_en = 1.
  - miss_l alone: score2 += 1, serve_dir = 0, go to POINT.
  - miss_r alone: score1 += 1, serve_dir = 1, go to POINT.
  - miss_l and miss_r in the same cycle: no score, serve_dir unchanged, go to POINT.
  - start_rise with no miss: go to PAUSE.
  - A miss takes priority over start_rise.
- PAUSE (011): motion_en = 0. miss_l and miss_r are ignored. On start_rise, go to PLAY.
- POINT (100): motion_en = 0. Counter counts POINT_FRAMES ticks, then:
  - if score1 == MAX_SCORE: winner = 01, go to GAMEOVER;
  - else if score2 == MAX_SCORE: winner = 10, go to GAMEOVER;
  - else go to SERVE.
- GAMEOVER (101): motion_en = 0. Scores and winner hold. On start_rise: clear scores and winner, serve_dir = 0, go to SERVE.
- Unused encodings 110 and 111 go to IDLE on the next cycle.
- Scores saturate at MAX_SCORE. They are 4-bit unsigned and never wrap.

## Timing
- All outputs are registered and update on the clock edge that changes state.
- Reset values:
  - state = IDLE, score1 = score2 = 0, winner = 00, serve_dir = 0;
  - motion_en = 0, ball_center = 0, frame counter = 0;
  - start_q = 1, so a button held through reset does not start a game.
- ball_center is high for exactly the first cycle after entering SERVE from IDLE or GAMEOVER, and the first cycle after entering POINT. It is never high in two consecutive cycles.
- The frame counter clears on every state entry. It advances only on frame_tick. The exit transition fires on the cycle the counter equals N-1 and frame_tick is high, so the exit lands exactly N ticks after entry.
- A frame_tick in the same cycle as the state entry does not count.
- A score update is visible on score1/score2 one cycle after the miss pulse, coincident with state = POINT.
- motion_en drops on the same edge that leaves PLAY. The datapath sees no frame_tick with motion_en = 1 after a miss.
- Reset asserted mid-game takes effect at the next edge, regardless of state or counter.

## Structure
- Shared package pong_pkg holds:
  - the state encoding constants (IDLE..GAMEOVER);
  - the winner codes;
  - the 4-bit score width.
- pong_pkg is shared with the animation datapath and the score overlay.
- Sub-module pong_frame_timer: 8-bit counter with clear, tick-enable and terminal-count compare. It is instantiated once, and terminal count is selected by state (SERVE_FRAMES or POINT_FRAMES).

## Test plan
- Reset behaviour: reset with start held high, then release reset. Required: state stays IDLE, no ball_center, all outputs at reset values. Then drop and raise start: SERVE entered, one ball_center pulse, serve_dir = 0.
- Serve timing: SERVE_FRAMES = 3, with frame_tick every 10 cycles. Required: PLAY entered on the 3rd tick, motion_en rises on that same edge.
- Scoring: in PLAY, pulse miss_r. Required: next cycle score1 = 1, serve_dir = 1, state = POINT, ball_center pulse. After POINT_FRAMES ticks, state = SERVE.
- Simultaneous miss: miss_l and miss_r in the same cycle. Required: scores unchanged, state = POINT, serve_dir unchanged.
- Pause: start_rise in PLAY. Required: PAUSE entered, motion_en = 0, a miss_l during PAUSE leaves score2 unchanged. A second start_rise returns to PLAY.
- Win: MAX_SCORE = 2, P2 scores twice. Required: after the second POINT, winner = 10, state = GAMEOVER, score2 = 2. Then start_rise: scores = 0, winner = 00, state = SERVE, ball_center pulse.

Source files
------------

// File: rtl/pong_pkg.sv
// pong_pkg
// Shared definitions for the pong game-flow controller, the animation
// datapath and the score overlay.
//   - state_t       : match state encoding (IDLE..GAMEOVER)
//   - WIN_*         : winner codes presented on the winner output
//   - SCORE_W       : width of each player's score
//   - FRAME_CNT_W   : width of the per-state frame counter
//   - score_inc()   : saturating score increment
package pong_pkg;

    localparam int SCORE_W     = 4;
    localparam int FRAME_CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'b000,
        ST_SERVE    = 3'b001,
        ST_PLAY     = 3'b010,
        ST_PAUSE    = 3'b011,
        ST_POINT    = 3'b100,
        ST_GAMEOVER = 3'b101
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    // Scores stop at the winning value so they can never wrap.
    function automatic logic [SCORE_W-1:0] score_inc(
        input logic [SCORE_W-1:0] cur,
        input logic [SCORE_W-1:0] max_val
    );
        return (cur >= max_val) ? cur : cur + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/pong_frame_timer.sv
// pong_frame_timer
// Counts frame ticks since the last clear and flags the tick that reaches
// the terminal count.
//   clk      in   clock
//   reset    in   synchronous active-high reset
//   i_clear  in   restart counting from zero; a tick in this cycle is dropped
//   i_tick   in   frame tick, advances the counter
//   i_term   in   terminal count N (1..255)
//   o_done   out  high on the cycle of the N-th counted tick
module pong_frame_timer
    import pong_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_clear,
    input  logic                   i_tick,
    input  logic [FRAME_CNT_W-1:0] i_term,
    output logic                   o_done
);

    logic [FRAME_CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_tick) begin
            r_count <= r_count + FRAME_CNT_W'(1);
        end
    end

    // Counter holds N-1 when the N-th tick arrives; a clear cycle never completes.
    assign o_done = i_tick & ~i_clear & (r_count == i_term - FRAME_CNT_W'(1));

endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl
// Game-flow sequencer: owns match state, both scores and the winner, and
// gates the ball/paddle datapath.
//   clk          in   pixel clock
//   reset        in   synchronous active-high reset
//   frame_tick   in   one pulse per frame
//   start        in   debounced start/pause button (level)
//   miss_l       in   ball passed left paddle -> point to P2
//   miss_r       in   ball passed right paddle -> point to P1
//   motion_en    out  datapath may advance ball and paddles
//   ball_center  out  one-cycle recentre pulse
//   serve_dir    out  serve direction after recentre (0 left, 1 right)
//   score1/2     out  player scores
//   winner       out  00 none, 01 P1, 10 P2
//   state        out  current state encoding
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int MAX_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               miss_l,
    input  logic               miss_r,
    output logic               motion_en,
    output logic               ball_center,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [1:0]         winner,
    output logic [2:0]         state
);

    localparam logic [SCORE_W-1:0] MAX_S = SCORE_W'(MAX_SCORE);

    state_t               r_state;
    logic                 r_start_q;
    logic                 r_motion_en;
    logic                 r_ball_center;
    logic                 r_serve_dir;
    logic                 r_timer_clr;
    logic [SCORE_W-1:0]   r_score1;
    logic [SCORE_W-1:0]   r_score2;
    logic [1:0]           r_winner;

    logic                   w_start_rise;
    logic                   w_done;
    logic [FRAME_CNT_W-1:0] w_term;

    assign w_start_rise = start & ~r_start_q;
    assign w_term = (r_state == ST_POINT) ? FRAME_CNT_W'(POINT_FRAMES)
                                          : FRAME_CNT_W'(SERVE_FRAMES);

    // r_timer_clr is raised on every transition, so the counter is cleared
    // during the first cycle of each new state and a tick there is not counted.
    pong_frame_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .i_clear (r_timer_clr),
        .i_tick  (frame_tick),
        .i_term  (w_term),
        .o_done  (w_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_start_q     <= 1'b1;   // a button held through reset is not a press
            r_motion_en   <= 1'b0;
            r_ball_center <= 1'b0;
            r_serve_dir   <= 1'b0;
            r_timer_clr   <= 1'b0;
            r_score1      <= '0;
            r_score2      <= '0;
            r_winner      <= WIN_NONE;
        end else begin
            r_start_q     <= start;
            r_ball_center <= 1'b0;
            r_timer_clr   <= 1'b0;

            case (r_state)
                ST_IDLE, ST_GAMEOVER: begin
                    r_motion_en <= 1'b0;
                    if (w_start_rise) begin
                        r_score1      <= '0;
                        r_score2      <= '0;
                        r_winner      <= WIN_NONE;
                        r_serve_dir   <= 1'b0;
                        r_state       <= ST_SERVE;
                        r_ball_center <= 1'b1;
                        r_timer_clr   <= 1'b1;
                    end
                end

                ST_SERVE: begin
                    r_motion_en <= 1'b0;
                    if (w_done) begin
                        r_state     <= ST_PLAY;
                        r_motion_en <= 1'b1;
                        r_timer_clr <= 1'b1;
                    end
                end

                ST_PLAY: begin
                    r_motion_en <= 1'b1;
                    // Misses win over a pause press; a double miss scores nobody.
                    if (miss_l || miss_r) begin
                        if (miss_l && !miss_r) begin
                            r_score2    <= score_inc(r_score2, MAX_S);
                            r_serve_dir <= 1'b0;
                        end else if (miss_r && !miss_l) begin
                            r_score1    <= score_inc(r_score1, MAX_S);
                            r_serve_dir <= 1'b1;
                        end
                        r_state       <= ST_POINT;
                        r_motion_en   <= 1'b0;
                        r_ball_center <= 1'b1;
                        r_timer_clr   <= 1'b1;
                    end else if (w_start_rise) begin
                        r_state     <= ST_PAUSE;
                        r_motion_en <= 1'b0;
                        r_timer_clr <= 1'b1;
                    end
                end

                ST_PAUSE: begin
                    r_motion_en <= 1'b0;
                    if (w_start_rise) begin
                        r_state     <= ST_PLAY;
                        r_motion_en <= 1'b1;
                        r_timer_clr <= 1'b1;
                    end
                end

                ST_POINT: begin
                    r_motion_en <= 1'b0;
                    if (w_done) begin
                        r_timer_clr <= 1'b1;
                        if (r_score1 == MAX_S) begin
                            r_winner <= WIN_P1;
                            r_state  <= ST_GAMEOVER;
                        end else if (r_score2 == MAX_S) begin
                            r_winner <= WIN_P2;
                            r_state  <= ST_GAMEOVER;
                        end else begin
                            r_state  <= ST_SERVE;
                        end
                    end
                end

                default: begin
                    r_motion_en <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign motion_en   = r_motion_en;
    assign ball_center = r_ball_center;
    assign serve_dir   = r_serve_dir;
    assign score1      = r_score1;
    assign score2      = r_score2;
    assign winner      = r_winner;
    assign state       = r_state;

endmodule
